// File: rtl/fpu_pkg.sv
// Shared constants and types for the FP add/sub issue controller.
// Optional feature macro used by the top: FPU_STICKY_OVF_EN.
package fpu_pkg;

    localparam int FP_W      = 32;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int SIGN_BIT  = 31;
    localparam int RES_TAG_W = 5;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Result entry layout at the default tag width: {y, ovf, tag}.
    typedef struct packed {
        logic [FP_W-1:0]      y;
        logic                 ovf;
        logic [RES_TAG_W-1:0] tag;
    } fpu_res_t;

    // The core only subtracts, so an add is issued as x1 - (-x2).
    function automatic logic [FP_W-1:0] core_operand2(input logic [FP_W-1:0] x2,
                                                      input logic            sub);
        return {x2[SIGN_BIT] ^ (sub == OP_ADD), x2[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO with first-word-fall-through output and occupancy count.
// Output data is forced to zero while the FIFO is empty.
module fpu_res_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 38
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || i_pop);

    assign o_data  = w_empty ? '0 : r_mem[r_rd];
    assign o_count = r_count;

    // Storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and occupancy update; flush discards everything.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // The credit scheme upstream must never let a push hit a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst || i_flush)
                                    !(i_push && w_full && !i_pop));

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/collect controller for a fixed-latency FP subtract core.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// the sender holds its payload stable until then.
// Optional feature macro: FPU_STICKY_OVF_EN (sticky overflow flag with clear input).
module fpu_addsub_issue
    import fpu_pkg::*;
#(
    parameter int CORE_LAT = 4,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = RES_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_sub,
    input  logic [FP_W-1:0]   req_x1,
    input  logic [FP_W-1:0]   req_x2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [FP_W-1:0]   core_x1,
    output logic [FP_W-1:0]   core_x2,
    input  logic [FP_W-1:0]   core_y,
    input  logic              core_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP_W-1:0]   res_y,
    output logic              res_ovf,
    output logic [TAG_W-1:0]  res_tag
`ifdef FPU_STICKY_OVF_EN
    ,
    input  logic              sticky_clr,
    output logic              sticky_ovf
`endif
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = FP_W + 1 + TAG_W;

    logic [CNT_W-1:0]   r_outstanding;
    logic [FP_W-1:0]    r_x1;
    logic [FP_W-1:0]    r_x2;
    // Index 0 is loaded on the accept edge alongside the operand registers;
    // index CORE_LAT lines up with the core output being valid.
    logic [CORE_LAT:0]  r_chain_vld;
    logic [TAG_W-1:0]   r_chain_tag [0:CORE_LAT];

    logic               w_accept;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_fifo_count;

    assign req_ready = !rst && !flush && (r_outstanding < CNT_W'(DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = res_valid && res_ready;

    assign core_x1 = r_x1;
    assign core_x2 = r_x2;

    // Operand registers feeding the core; they hold between accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x1 <= '0;
            r_x2 <= '0;
        end else if (w_accept) begin
            r_x1 <= req_x1;
            r_x2 <= core_operand2(req_x2, req_sub);
        end
    end

    // Valid bits track each op through the core; flush drops them all.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_chain_vld <= '0;
        end else begin
            r_chain_vld[0] <= w_accept;
            for (int i = 1; i <= CORE_LAT; i++) begin
                r_chain_vld[i] <= r_chain_vld[i-1];
            end
        end
    end

    // Tags ride alongside the valid bits; they only matter where valid is set.
    always_ff @(posedge clk) begin
        r_chain_tag[0] <= req_tag;
        for (int i = 1; i <= CORE_LAT; i++) begin
            r_chain_tag[i] <= r_chain_tag[i-1];
        end
    end

    // Credit counter: one credit per op between accept and result pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_pop) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (w_pop && !w_accept) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    assign w_push_data = {core_y, core_ovf, r_chain_tag[CORE_LAT]};

    fpu_res_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (r_chain_vld[CORE_LAT]),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign res_valid = (w_fifo_count != '0);
    assign {res_y, res_ovf, res_tag} = w_head;

`ifdef FPU_STICKY_OVF_EN
    logic r_sticky;

    // Sticky overflow: set by a popped overflowing result, set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_pop && res_ovf) begin
            r_sticky <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign sticky_ovf = r_sticky;
`endif

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed bench for fpu_addsub_issue with a 4-stage behavioural core stub.
// Build with FPU_STICKY_OVF_EN defined to also exercise the sticky overflow flag.
module tb_fpu_addsub_issue;

    localparam int CORE_LAT = 4;
    localparam int DEPTH    = 8;
    localparam int TAG_W    = 5;
    localparam int EW       = 32 + 1 + TAG_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_sub = 1'b0;
    logic [31:0]       req_x1 = '0;
    logic [31:0]       req_x2 = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic [31:0]       core_x1;
    logic [31:0]       core_x2;
    logic [31:0]       core_y;
    logic              core_ovf;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [31:0]       res_y;
    logic              res_ovf;
    logic [TAG_W-1:0]  res_tag;
`ifdef FPU_STICKY_OVF_EN
    logic              sticky_clr = 1'b0;
    logic              sticky_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];
    int            pop_cyc[$];

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fpu_addsub_issue #(
        .CORE_LAT (CORE_LAT),
        .DEPTH    (DEPTH),
        .TAG_W    (TAG_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_tag   (req_tag),
        .core_x1   (core_x1),
        .core_x2   (core_x2),
        .core_y    (core_y),
        .core_ovf  (core_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_ovf   (res_ovf),
        .res_tag   (res_tag)
`ifdef FPU_STICKY_OVF_EN
        ,
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf)
`endif
    );

    // Core stub: computes a - b for the known vectors, a ^ b otherwise.
    function automatic logic [32:0] core_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40400000_3F800000: return {1'b0, 32'h40000000};
            64'h3FC00000_C0100000: return {1'b0, 32'h40700000};
            64'h3F800000_3F800000: return {1'b0, 32'h00000000};
            64'h7F7FFFFF_FF7FFFFF: return {1'b1, 32'h7F800000};
            default:               return {1'b0, a ^ b};
        endcase
    endfunction

    logic [32:0] core_pipe [0:CORE_LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= core_model(core_x1, core_x2);
        for (int i = 1; i < CORE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign {core_ovf, core_y} = core_pipe[CORE_LAT-1];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Scoreboard: every popped result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {32'h0, res_y}, 64'hDEAD);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("res_y", res_y, e[EW-1:TAG_W+1]);
                chk("res_ovf", res_ovf, e[TAG_W]);
                chk("res_tag", res_tag, e[TAG_W-1:0]);
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Driver: present a request and hold it until accepted; leaves req_valid high.
    task automatic send(input logic sub, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [TAG_W-1:0] tag, input logic [EW-1:0] exp,
                        input bit track, output int stalls);
        bit acc;
        req_sub = sub; req_x1 = x1; req_x2 = x2; req_tag = tag; req_valid = 1'b1;
        stalls = 0;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                if (track) exp_q.push_back(exp);
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_core_x1"}, core_x1, 0);
        chk({pfx, "_core_x2"}, core_x2, 0);
        chk({pfx, "_res_y"}, res_y, 0);
        chk({pfx, "_res_ovf"}, res_ovf, 0);
        chk({pfx, "_res_tag"}, res_tag, 0);
    endtask

    initial begin
        int st;
        int tot;
        int n;
        int seen;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] cx2;
        logic        sub;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;

        // fsub 3.0 - 1.0, tag 7, with accept-to-res_valid latency.
        send(1'b1, 32'h40400000, 32'h3F800000, 5'd7, {32'h40000000, 1'b0, 5'd7}, 1'b1, st);
        idle();
        chk("sub_core_x1", core_x1, 32'h40400000);
        chk("sub_core_x2", core_x2, 32'h3F800000);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk);
            n++;
        end
        chk("latency", n, CORE_LAT + 1);
        @(posedge clk); #1;
        wait_drain("drain_sub");

        // fadd 1.5 + 2.25: sign of x2 flipped toward the core.
        send(1'b0, 32'h3FC00000, 32'h40100000, 5'd3, {32'h40700000, 1'b0, 5'd3}, 1'b1, st);
        idle();
        chk("add_core_x2", core_x2, 32'hC0100000);
        wait_drain("drain_add");

        // Eight back-to-back requests, tags 0..7, no stalls, consecutive results.
        pop_cyc.delete();
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            x1  = 32'h1000_0000 + i;
            x2  = 32'h0000_1111 * i;
            sub = i[0];
            cx2 = sub ? x2 : (x2 ^ 32'h8000_0000);
            send(sub, x1, x2, TAG_W'(i), {x1 ^ cx2, 1'b0, TAG_W'(i)}, 1'b1, st);
            tot += st;
        end
        idle();
        chk("burst_stalls", tot, 0);
        wait_drain("drain_burst");
        chk("burst_pops", pop_cyc.size(), 8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++) begin
            chk("burst_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);
        end

        // Backpressure: fill all credits, then a held request waits.
        res_ready = 1'b0;
        tot = 0;
        for (int i = 0; i < DEPTH; i++) begin
            x1 = 32'h2000_0000 + i;
            x2 = 32'h0000_0100 + i;
            send(1'b1, x1, x2, TAG_W'(10 + i), {x1 ^ x2, 1'b0, TAG_W'(10 + i)}, 1'b1, st);
            tot += st;
        end
        chk("fill_stalls", tot, 0);
        req_sub = 1'b1; req_x1 = 32'h3000_0000; req_x2 = 32'h0000_0055; req_tag = 5'd30;
        req_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_req_ready", req_ready, 0);
        chk("full_res_valid", res_valid, 1);
        chk("full_head_tag", res_tag, 10);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("held_res_y", res_y, 32'h2000_0000 ^ 32'h0000_0100);
        chk("held_res_tag", res_tag, 10);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("pre_pop_req_ready", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_pop_req_ready", req_ready, 1);
        if (req_ready) exp_q.push_back({32'h3000_0055, 1'b0, 5'd30});
        @(posedge clk); #1;
        idle();
        wait_drain("drain_backpressure");

        // Flush with three ops in flight: none may come out.
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 32'h4000_0000 + i, 32'h1, TAG_W'(20 + i), '0, 1'b0, st);
        end
        idle();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", req_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("flush_no_result", seen, 0);
        chk("flush_outstanding", u_dut.r_outstanding, 0);
        @(posedge clk); #1;
        send(1'b1, 32'h3F800000, 32'h3F800000, 5'd9, {32'h00000000, 1'b0, 5'd9}, 1'b1, st);
        idle();
        wait_drain("drain_after_flush");

        // Overflow: max finite + max finite.
        send(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd17, {32'h7F800000, 1'b1, 5'd17}, 1'b1, st);
        idle();
        chk("ovf_core_x2", core_x2, 32'hFF7FFFFF);
        wait_drain("drain_ovf");
`ifdef FPU_STICKY_OVF_EN
        @(posedge clk); #1;
        @(negedge clk);
        chk("sticky_set", sticky_ovf, 1);
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", sticky_ovf, 0);
`endif

        // Reset mid-run with ops in flight: outputs return to reset values, nothing stale.
        @(posedge clk); #1;
        send(1'b1, 32'h5000_0000, 32'h2, 5'd25, '0, 1'b0, st);
        send(1'b0, 32'h5000_0001, 32'h3, 5'd26, '0, 1'b0, st);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
`ifdef FPU_STICKY_OVF_EN
        chk("midrst_sticky", sticky_ovf, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("midrst_no_stale", seen, 0);
        @(posedge clk); #1;
        send(1'b1, 32'h40400000, 32'h3F800000, 5'd4, {32'h40000000, 1'b0, 5'd4}, 1'b1, st);
        idle();
        wait_drain("drain_after_reset");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
